// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the mesh router.
//   - Output port indices (N, E, S, W, L) and the port count.
//   - Default header positions of the multicast flag and the 5-bit output mask.
//   - Helper functions that operate on the 32-bit header word: the low 32 bits of a flit.
package noc_flit_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_N    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_S    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_L    = 4;

  localparam int HDR_W          = 32;
  localparam int MCAST_FLAG_BIT = 31;
  localparam int MCAST_MASK_LSB = 26;

  typedef logic [NUM_PORTS-1:0] port_mask_t;

  function automatic logic flit_is_mcast(input logic [HDR_W-1:0] hdr,
                                         input logic [4:0]       flag_bit);
    return hdr[flag_bit];
  endfunction

  function automatic port_mask_t flit_mask(input logic [HDR_W-1:0] hdr,
                                           input logic [4:0]       mask_lsb);
    return hdr[mask_lsb +: NUM_PORTS];
  endfunction

  function automatic logic [HDR_W-1:0] flit_clear_mcast(input logic [HDR_W-1:0] hdr,
                                                        input logic [4:0]       flag_bit);
    logic [HDR_W-1:0] r;
    r           = hdr;
    r[flag_bit] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mcast_replicate_tx.sv
// Per-input-port transmit stage of the mesh router.
// It takes the flit at the input FIFO head and drives it to one or more of the
// five router outputs. A multicast flit is issued atomically to every port in
// its header mask. A unicast flit is issued to the single port given by in_route.
// Each port drains independently. A new flit is accepted only when no port is
// still holding the current one. Malformed flits are consumed and counted.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   in_flit      flit at the FIFO head
//   in_valid     in_flit valid
//   in_route     XY-routed unicast port (N=0, E=1, S=2, W=3, L=4)
//   in_ready     flit consumed this cycle
//   out_flit     per-port flit; port p occupies [p*FLIT_W +: FLIT_W]
//   out_valid    per-port valid
//   out_ready    per-port downstream ready
//   drop_pulse   one-cycle pulse after a malformed flit is discarded
//   mcast_cnt    multicast flits whose copies have all been delivered
//   drop_cnt     discarded flits
// FLIT_W must be at least 32, because the header occupies the low 32 bits.
module mcast_replicate_tx #(
  parameter int FLIT_W              = 64,
  parameter int ENABLE_MCAST        = 1,
  parameter int MCAST_CLEAR_ON_SEND = 1,
  parameter int MCAST_FLAG_BIT      = noc_flit_pkg::MCAST_FLAG_BIT,
  parameter int MCAST_MASK_LSB      = noc_flit_pkg::MCAST_MASK_LSB,
  parameter int CNT_W               = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FLIT_W-1:0]   in_flit,
  input  logic                in_valid,
  input  logic [2:0]          in_route,
  output logic                in_ready,
  output logic [5*FLIT_W-1:0] out_flit,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic                drop_pulse,
  output logic [CNT_W-1:0]    mcast_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  import noc_flit_pkg::*;

  logic [HDR_W-1:0]  hdr;
  logic              is_mc;
  port_mask_t        route_oh;
  port_mask_t        tgt;
  logic [FLIT_W-1:0] flit_d;
  logic              accept;
  logic              issue_done;
  logic              malformed;

  port_mask_t        pending;
  logic [FLIT_W-1:0] flit_q;
  logic              mc_q;

  assign hdr = in_flit[HDR_W-1:0];

  always_comb begin
    is_mc    = (ENABLE_MCAST != 0) && flit_is_mcast(hdr, 5'(MCAST_FLAG_BIT));
    route_oh = '0;
    if (in_route < 3'(NUM_PORTS)) route_oh[in_route] = 1'b1;
    tgt      = is_mc ? flit_mask(hdr, 5'(MCAST_MASK_LSB)) : route_oh;
    flit_d   = in_flit;
    if (is_mc && (MCAST_CLEAR_ON_SEND != 0))
      flit_d[HDR_W-1:0] = flit_clear_mcast(hdr, 5'(MCAST_FLAG_BIT));
  end

  // Ready as soon as every still-pending port drains this cycle, so a new
  // flit can load on the same edge that the last copy leaves.
  assign in_ready   = ~|(pending & ~out_ready);
  assign accept     = in_valid & in_ready;
  assign issue_done = (|pending) & in_ready;
  // An empty target set covers both a zero-mask multicast and an out-of-range route.
  assign malformed  = (tgt == '0);

  // Control and counters. issue_done counts the flit being retired, even if
  // a new flit is accepted on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      mc_q       <= 1'b0;
      drop_pulse <= 1'b0;
      mcast_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= accept && malformed;
      if (accept) begin
        pending <= tgt;
        mc_q    <= is_mc;
      end else begin
        pending <= pending & ~out_ready;
      end
      if (issue_done && mc_q)   mcast_cnt <= mcast_cnt + CNT_W'(1);
      if (accept && malformed)  drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end

  // The data register is not reset. The outputs are gated by pending, so the
  // stale contents are never visible.
  always_ff @(posedge clk) begin
    if (accept) flit_q <= flit_d;
  end

  assign out_valid = pending;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign out_flit[p*FLIT_W +: FLIT_W] = pending[p] ? flit_q : '0;
  end

endmodule

// File: tb/tb_mcast_replicate_tx.sv
module tb_mcast_replicate_tx;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_flit = '0;
  logic         in_valid = 1'b0;
  logic [2:0]   in_route = '0;
  logic [4:0]   out_ready = '1;

  logic         in_ready;
  logic [5*W-1:0] out_flit;
  logic [4:0]   out_valid;
  logic         drop_pulse;
  logic [15:0]  mcast_cnt, drop_cnt;

  logic         nm_ready;
  logic [5*W-1:0] nm_flit;
  logic [4:0]   nm_valid;
  logic         nm_drop;
  logic [15:0]  nm_mcnt, nm_dcnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [4:0]   m_busy = '0;
  logic [W-1:0] m_word = '0;
  logic         m_mc = 1'b0;
  logic         m_drop = 1'b0;
  logic [15:0]  m_mcnt = '0;
  logic [15:0]  m_dcnt = '0;

  always #5 clk = ~clk;

  mcast_replicate_tx #(.FLIT_W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
    .in_route(in_route), .in_ready(in_ready), .out_flit(out_flit),
    .out_valid(out_valid), .out_ready(out_ready), .drop_pulse(drop_pulse),
    .mcast_cnt(mcast_cnt), .drop_cnt(drop_cnt)
  );

  mcast_replicate_tx #(.FLIT_W(W), .ENABLE_MCAST(0)) u_nm (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
    .in_route(in_route), .in_ready(nm_ready), .out_flit(nm_flit),
    .out_valid(nm_valid), .out_ready(out_ready), .drop_pulse(nm_drop),
    .mcast_cnt(nm_mcnt), .drop_cnt(nm_dcnt)
  );

  function automatic logic [W-1:0] mk(input logic flag, input logic [4:0] mask,
                                      input logic [7:0] row, input logic [7:0] col,
                                      input logic [31:0] payload);
    return {payload, flag, mask, 10'h000, row, col};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_ready();
    logic r;
    r = 1'b1;
    for (int p = 0; p < 5; p++) if (m_busy[p] && !out_ready[p]) r = 1'b0;
    return r;
  endfunction

  // The model works from the rules: a port holds its copy until it sees ready.
  // A flit is taken only when nothing is left waiting. A flit with no target
  // port is counted as a drop.
  task automatic model_step();
    logic       rdy, mc;
    logic [4:0] t;
    if (!rst_n) begin
      m_busy = '0; m_mc = 1'b0; m_drop = 1'b0; m_mcnt = '0; m_dcnt = '0;
      return;
    end
    rdy    = model_ready();
    m_drop = 1'b0;
    if (rdy && (m_busy != 5'd0) && m_mc) m_mcnt = m_mcnt + 16'd1;
    for (int p = 0; p < 5; p++) if (out_ready[p]) m_busy[p] = 1'b0;
    if (in_valid && rdy) begin
      mc = in_flit[31];
      t  = '0;
      if (mc) begin
        for (int p = 0; p < 5; p++) t[p] = in_flit[26+p];
      end else if (in_route <= 3'd4) begin
        t[in_route] = 1'b1;
      end
      m_busy = t;
      m_mc   = mc;
      m_word = in_flit;
      if (mc) m_word[31] = 1'b0;
      if (t == 5'd0) begin
        m_drop = 1'b1;
        m_dcnt = m_dcnt + 16'd1;
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", W'(out_valid), W'(m_busy));
    for (int p = 0; p < 5; p++)
      chk($sformatf("out_flit[%0d]", p), out_flit[p*W +: W], m_busy[p] ? m_word : '0);
    chk("in_ready", W'(in_ready), W'(model_ready()));
    chk("drop_pulse", W'(drop_pulse), W'(m_drop));
    chk("mcast_cnt", W'(mcast_cnt), W'(m_mcnt));
    chk("drop_cnt", W'(drop_cnt), W'(m_dcnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input logic [W-1:0] f, input logic [2:0] r);
    int n;
    n        = 0;
    in_flit  = f;
    in_route = r;
    in_valid = 1'b1;
    while (!model_ready() && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: waited %0d cycles for ready, required < 50", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  logic [W-1:0] f;

  initial begin
    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_counters", W'({mcast_cnt, drop_cnt}), '0);
    chk("reset_in_ready", W'(in_ready), W'(1));

    // 1: multicast to E and L, dest (0,1)
    out_ready = 5'b11111;
    f = mk(1'b1, 5'b10010, 8'd0, 8'd1, 32'hA5A5_0001);
    send(f, 3'd0);
    chk("t1_valid", W'(out_valid), W'(5'b10010));
    chk("t1_flit_e", out_flit[1*W +: W], 64'hA5A5_0001_4800_0001);
    chk("t1_flit_l", out_flit[4*W +: W], 64'hA5A5_0001_4800_0001);
    tick();
    chk("t1_mcnt", W'(mcast_cnt), W'(1));
    chk("t1_ready", W'(in_ready), W'(1));

    // 2: staggered drain
    out_ready = 5'b00001;
    send(mk(1'b1, 5'b00111, 8'd2, 8'd2, 32'h0000_0002), 3'd0);
    chk("t2_valid0", W'(out_valid), W'(5'b00111));
    chk("t2_hold_ready", W'(in_ready), W'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_valid_hold", W'(out_valid), W'(5'b00110));
    end
    chk("t2_mcnt_hold", W'(mcast_cnt), W'(1));
    out_ready = 5'b11111;
    tick();
    chk("t2_drained", W'(out_valid), W'(0));
    chk("t2_mcnt", W'(mcast_cnt), W'(2));

    // 3: unicast to S, bit-exact
    send(mk(1'b0, 5'b10101, 8'd2, 8'd3, 32'h1234_5678), 3'd2);
    chk("t3_valid", W'(out_valid), W'(5'b00100));
    chk("t3_flit", out_flit[2*W +: W], 64'h1234_5678_5400_0203);
    tick();
    chk("t3_mcnt", W'(mcast_cnt), W'(2));

    // 4: malformed flits
    send(mk(1'b1, 5'b00000, 8'd1, 8'd1, 32'h0000_0004), 3'd1);
    chk("t4_valid_a", W'(out_valid), W'(0));
    chk("t4_drop_a", W'(drop_pulse), W'(1));
    send(mk(1'b0, 5'b00000, 8'd1, 8'd1, 32'h0000_0005), 3'd5);
    chk("t4_drop_b", W'(drop_pulse), W'(1));
    chk("t4_dcnt", W'(drop_cnt), W'(2));
    tick();
    chk("t4_drop_end", W'(drop_pulse), W'(0));

    // 5: back-to-back multicast
    send(mk(1'b1, 5'b00011, 8'd0, 8'd0, 32'h0000_0006), 3'd0);
    chk("t5_first", W'(out_valid), W'(5'b00011));
    send(mk(1'b1, 5'b01100, 8'd0, 8'd0, 32'h0000_0007), 3'd0);
    chk("t5_second", W'(out_valid), W'(5'b01100));
    chk("t5_mcnt_mid", W'(mcast_cnt), W'(3));
    tick();
    chk("t5_mcnt", W'(mcast_cnt), W'(4));

    // 6: asynchronous reset in the middle of an issue
    out_ready = 5'b00000;
    send(mk(1'b1, 5'b11111, 8'd0, 8'd0, 32'h0000_0008), 3'd0);
    chk("t6_valid", W'(out_valid), W'(5'b11111));
    #2 rst_n = 1'b0;
    model_step();
    #1;
    chk("t6_rst_valid", W'(out_valid), W'(0));
    chk("t6_rst_mcnt", W'(mcast_cnt), W'(0));
    chk("t6_rst_dcnt", W'(drop_cnt), W'(0));
    compare();
    tick();
    rst_n = 1'b1;
    out_ready = 5'b11111;
    tick();
    tick();
    chk("t6_no_residual", W'(out_valid), W'(0));

    // With multicast disabled, a flagged flit follows in_route and keeps bit 31
    send(mk(1'b1, 5'b11111, 8'd0, 8'd0, 32'hDEAD_BEEF), 3'd3);
    chk("t6_nm_valid", W'(nm_valid), W'(5'b01000));
    chk("t6_nm_flit", nm_flit[3*W +: W], 64'hDEAD_BEEF_FC00_0000);
    chk("t6_nm_mcnt", W'(nm_mcnt), W'(0));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcast_replicate_tx.md
Name: mcast_replicate_tx

Overview:
- Per-input-port transmit stage of the mesh router: takes one flit from the input FIFO head and drives it to one or more of the five router outputs.
- For multicast flits it replicates atomically to every output selected by the header mask.
- With MCAST_CLEAR_ON_SEND=1 it clears the multicast flag on every copy, so downstream routers treat the copies as unicast.
- It is the sender side of the one-hop multicast semantic that downstream local ports check.

Parameters:
- FLIT_W, 64, flit width in bits.
- ENABLE_MCAST, 1, 0 treats every flit as unicast regardless of bit 31.
- MCAST_CLEAR_ON_SEND, 1, 1 clears the flag bit on all emitted copies.
- MCAST_FLAG_BIT, 31, header multicast flag position.
- MCAST_MASK_LSB, 26, LSB of the 5-bit output mask field.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_flit  in  FLIT_W  flit at the FIFO head
- in_valid  in  1  in_flit valid
- in_route  in  3  unicast output port from XY routing: N=0, E=1, S=2, W=3, L=4
- in_ready  out  1  flit consumed this cycle
- out_flit  out  5*FLIT_W  per-port flit; port p occupies [p*FLIT_W +: FLIT_W]
- out_valid  out  5  per-port valid
- out_ready  in  5  per-port downstream ready
- drop_pulse  out  1  one-cycle pulse when a malformed flit is discarded
- mcast_cnt  out  CNT_W  multicast flits fully issued
- drop_cnt  out  CNT_W  flits dropped

Behaviour:

Header and port mapping
- mask = in_flit[MCAST_MASK_LSB +: 5]. mask[p] selects port p, using the same port numbering as in_route.
- A flit is multicast when ENABLE_MCAST=1 and in_flit[MCAST_FLAG_BIT]=1.

Reset
- out_valid=0, out_flit=0, pending=0, drop_pulse=0, both counters=0.
- rst_n assertion mid-issue discards the in-flight flit. No partial copies persist.

Registers and handshake
- Internal registers: flit_q (FLIT_W) and pending (5 bits). Port p holds a flit while pending[p]=1.
- in_ready = ~|(pending & ~out_ready). Back-to-back acceptance is allowed in the cycle the last pending port drains.
- Accept happens when in_valid & in_ready. On accept:
  - Target set T = mask when multicast, else one-hot(in_route).
  - pending <= T. A drained port p with T[p]=0 clears to 0.
  - flit_q <= in_flit, with the flag bit forced to 0 when the flit is multicast and MCAST_CLEAR_ON_SEND=1.
  - Mask bits pass through unchanged. All other bits, including dest row [15:8] and col [7:0], pass through unchanged.

Output timing
- Latency is 1 cycle: a flit accepted at edge t shows out_valid on all ports in T after edge t.
- All copies appear in the same cycle (atomic issue). All copies carry identical out_flit.
- out_valid = pending. out_flit for port p = flit_q when pending[p], else 0.
- Ports drain independently: pending[p] clears at an edge where pending[p] & out_ready[p].
- A port that has drained is never re-driven with the same flit.

States
- IDLE (pending=0) and ISSUE (pending≠0). The state is implicit in pending.

Malformed flits
- Multicast with mask=0, or unicast with in_route>4, is still accepted (in_ready behaves normally).
- No output is driven. drop_pulse=1 in the next cycle. drop_cnt increments.

Statistics counters
- mcast_cnt increments in the cycle pending transitions to 0 for a multicast flit, i.e. all copies delivered.
- Both counters wrap modulo 2^CNT_W.

Simultaneous events
- When the final pending port drains in the same cycle a new flit is accepted, the new T loads. There are no bubbles.

Decomposition:
- Package noc_flit_pkg holds:
  - port index constants (PORT_N..PORT_L, NUM_PORTS=5)
  - MCAST_FLAG_BIT and MCAST_MASK_LSB
  - helper functions flit_is_mcast, flit_mask, flit_clear_mcast
- No sub-module is needed. The counters are inline. A router instantiates one mcast_replicate_tx per input port ahead of the arbiter.

Test Plan:
1. Multicast E+L: in_flit flag=1, mask=5'b10010 (E, L), dest (0,1), all out_ready=1 → out_valid=5'b10010 one cycle after accept, out_flit[1]==out_flit[4], bit31=0, mcast_cnt=1, in_ready high again next cycle.
2. Staggered drain: mask=5'b00111, out_ready=5'b00001 for 3 cycles, then all 1 → out_valid goes 00111→00110 and stays until release; in_ready=0 during the hold; port 0 is never re-asserted; mcast_cnt increments only after the last drain.
3. Unicast: flag=0, in_route=2 → only out_valid[2] is asserted; flit is bit-exact to input; mcast_cnt unchanged.
4. Malformed: flag=1, mask=0, then flag=0 with in_route=5 → no out_valid; two drop_pulse cycles; drop_cnt=2.
5. Back-to-back: two multicast flits with masks 5'b00011 then 5'b01100, all ready → flits accepted on consecutive edges; out_valid sequence 00011, 01100; no idle cycle.
6. Reset mid-issue: mask=5'b11111, out_ready=0, assert rst_n=0 asynchronously → out_valid=0 immediately, counters=0; after release no residual flit appears. With ENABLE_MCAST=0, a flag=1 flit routes as unicast by in_route with bit31 preserved.
